mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Sequences each instruction through FETCH / DCD / EXE / MEM / WB and drives
// the datapath strobes and selects. Memory handshakes are bounded by a wait
// counter; an illegal instruction or a memory timeout parks the FSM in TRAP
// until reset. Also keeps a sticky addi-overflow flag and a retired count.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   op_i, funct_i          instruction[31:26] / instruction[5:0] from the IR
//   zero_i, overflow_i     ALU flags of the current cycle
//   imem_rdy_i, dmem_rdy_i memory ready handshakes
//   imem_req_o, dmem_req_o memory requests
//   PCWr_o .. byteOp_o     1-bit datapath strobes and selects
//   NPCop_o .. GPRsel_o    2-bit datapath selects
//   state_o                current FSM state
//   trap_o, trap_code_o    fault indication (01 illegal, 10 imem, 11 dmem)
//   ovf_flag_o             sticky addi overflow
//   retired_o              retired instruction count (wraps)
module mc_ctrl #(
   parameter int CNT_W    = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [5:0]       op_i,
   input  logic [5:0]       funct_i,
   input  logic             zero_i,
   input  logic             overflow_i,
   input  logic             imem_rdy_i,
   input  logic             dmem_rdy_i,
   output logic             imem_req_o,
   output logic             dmem_req_o,
   output logic             PCWr_o,
   output logic             IRWr_o,
   output logic             GPRWr_o,
   output logic             DMWr_o,
   output logic             ALUsrc_o,
   output logic             ALUsign_o,
   output logic             byteOp_o,
   output logic [1:0]       NPCop_o,
   output logic [1:0]       ALUop_o,
   output logic [1:0]       ExtOp_o,
   output logic [1:0]       M2Rsel_o,
   output logic [1:0]       GPRsel_o,
   output logic [2:0]       state_o,
   output logic             trap_o,
   output logic [1:0]       trap_code_o,
   output logic             ovf_flag_o,
   output logic [CNT_W-1:0] retired_o
);

   typedef enum logic [2:0] {
      FETCH = 3'd0, DCD = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7
   } state_e;

   // Last count value before a timeout: WAIT_MAX cycles without ready in total.
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_e           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [1:0]       code_q, code_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   // Instruction decode
   logic is_r, is_addu, is_subu, is_slt, is_jr, is_addi, is_ori, is_lui;
   logic is_lw, is_lb, is_sw, is_sb, is_beq, is_j, is_jal;
   logic is_load, is_store, is_itype, legal;

   assign is_r     = (op_i == 6'b000000);
   assign is_addu  = is_r && (funct_i == 6'b100001);
   assign is_subu  = is_r && (funct_i == 6'b100011);
   assign is_slt   = is_r && (funct_i == 6'b101010);
   assign is_jr    = is_r && (funct_i == 6'b001000);
   assign is_addi  = (op_i == 6'b001000);
   assign is_ori   = (op_i == 6'b001101);
   assign is_lui   = (op_i == 6'b001111);
   assign is_lw    = (op_i == 6'b100011);
   assign is_lb    = (op_i == 6'b100000);
   assign is_sw    = (op_i == 6'b101011);
   assign is_sb    = (op_i == 6'b101000);
   assign is_beq   = (op_i == 6'b000100);
   assign is_j     = (op_i == 6'b000010);
   assign is_jal   = (op_i == 6'b000011);
   assign is_load  = is_lw || is_lb;
   assign is_store = is_sw || is_sb;
   assign is_itype = is_addi || is_ori || is_lui || is_load || is_store;
   assign legal    = is_addu || is_subu || is_slt || is_jr || is_itype ||
                     is_beq || is_j || is_jal;

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      code_d    = code_q;
      ovf_d     = ovf_q;
      retired_d = retired_q;
      case (state_q)
         FETCH: begin
            if (imem_rdy_i)               state_d = DCD;
            else if (wait_q == WAIT_LAST) begin state_d = TRAP; code_d = 2'b10; end
            else                          wait_d = wait_q + 8'd1;
         end
         DCD: begin
            if (!legal)                        begin state_d = TRAP; code_d = 2'b01; end
            else if (is_j || is_jal || is_jr)  state_d = FETCH;
            else                               state_d = EXE;
         end
         EXE: begin
            if (is_beq)                     state_d = FETCH;
            else if (is_load || is_store)   state_d = MEM;
            else                            state_d = WB;
         end
         MEM: begin
            if (dmem_rdy_i)               state_d = is_store ? FETCH : WB;
            else if (wait_q == WAIT_LAST) begin state_d = TRAP; code_d = 2'b11; end
            else                          wait_d = wait_q + 8'd1;
         end
         WB: begin
            state_d = FETCH;
            if (is_addi && overflow_i) ovf_d = 1'b1;
         end
         TRAP:    state_d = TRAP;
         default: state_d = TRAP;
      endcase
      // Every state change restarts the wait count, so FETCH and MEM are
      // always entered with a fresh budget.
      if (state_d != state_q) wait_d = '0;
      if (state_d == FETCH && state_q != FETCH) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         code_q    <= 2'b00;
         ovf_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         code_q    <= code_d;
         ovf_q     <= ovf_d;
         retired_q <= retired_d;
      end
   end

   // Output decode; everything is held low while reset is asserted so an
   // aborted access never sees a write strobe.
   always_comb begin
      imem_req_o = 1'b0;  dmem_req_o = 1'b0;
      PCWr_o     = 1'b0;  IRWr_o     = 1'b0;
      GPRWr_o    = 1'b0;  DMWr_o     = 1'b0;
      ALUsrc_o   = 1'b0;  ALUsign_o  = 1'b0;
      byteOp_o   = 1'b0;
      NPCop_o    = 2'b00; ALUop_o    = 2'b00;
      ExtOp_o    = 2'b00; M2Rsel_o   = 2'b00;
      GPRsel_o   = 2'b00;
      if (rst_ni) begin
         // ALU selects stay valid from EXE to WB so the flags are live at write-back.
         if (state_q == EXE || state_q == MEM || state_q == WB) begin
            ALUsrc_o  = is_itype;
            ALUsign_o = is_addi || is_slt;
            ExtOp_o   = is_lui ? 2'b10 : (is_addi || is_load || is_store) ? 2'b01 : 2'b00;
            ALUop_o   = (is_subu || is_beq) ? 2'b01 :
                        (is_ori || is_lui)  ? 2'b10 :
                        is_slt              ? 2'b11 : 2'b00;
         end
         case (state_q)
            FETCH: begin
               imem_req_o = 1'b1;
               IRWr_o     = imem_rdy_i;
               PCWr_o     = imem_rdy_i;
            end
            DCD: begin
               if (is_j || is_jal) begin PCWr_o = 1'b1; NPCop_o = 2'b10; end
               if (is_jal) begin GPRWr_o = 1'b1; GPRsel_o = 2'b10; M2Rsel_o = 2'b10; end
               if (is_jr)  begin PCWr_o = 1'b1; NPCop_o = 2'b11; end
            end
            EXE: begin
               if (is_beq) begin PCWr_o = zero_i; NPCop_o = 2'b01; end
            end
            MEM: begin
               dmem_req_o = 1'b1;
               byteOp_o   = is_lb || is_sb;
               DMWr_o     = is_store && dmem_rdy_i;
            end
            WB: begin
               GPRWr_o  = !(is_addi && overflow_i);
               GPRsel_o = is_r ? 2'b00 : 2'b01;
               M2Rsel_o = is_load ? 2'b01 : 2'b00;
            end
            default: ;
         endcase
      end
   end

   assign state_o     = state_q;
   assign trap_o      = (state_q == TRAP);
   assign trap_code_o = code_q;
   assign ovf_flag_o  = ovf_q;
   assign retired_o   = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- self-checking bench for mc_ctrl (CNT_W=4, WAIT_MAX=4).
// A per-instruction route model checks every output on every cycle, while a
// vector table and hand-written sequences cover latency, strobe counts,
// timeouts, reset abort and counter wrap.
module tb_mc_ctrl;
   localparam int TB_CNT  = 4;
   localparam int TB_WAIT = 4;

   localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ADDI = 4, K_ORI = 5,
                  K_LUI = 6, K_LW = 7, K_LB = 8, K_SW = 9, K_SB = 10, K_BEQ = 11,
                  K_J = 12, K_JAL = 13, K_BAD = 14;

   logic clk = 1'b0, rst_n = 1'b1;
   logic [5:0] op = '0, funct = '0;
   logic zero = 1'b0, ovf = 1'b0, irdy = 1'b1, drdy = 1'b1;

   logic imem_req, dmem_req, PCWr, IRWr, GPRWr, DMWr, ALUsrc, ALUsign, byteOp;
   logic [1:0] NPCop, ALUop, ExtOp, M2Rsel, GPRsel, trap_code;
   logic [2:0] state;
   logic trap, ovf_flag;
   logic [TB_CNT-1:0] retired;

   int checks = 0, errors = 0;

   mc_ctrl #(.CNT_W(TB_CNT), .WAIT_MAX(TB_WAIT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
      .overflow_i(ovf), .imem_rdy_i(irdy), .dmem_rdy_i(drdy),
      .imem_req_o(imem_req), .dmem_req_o(dmem_req), .PCWr_o(PCWr), .IRWr_o(IRWr),
      .GPRWr_o(GPRWr), .DMWr_o(DMWr), .ALUsrc_o(ALUsrc), .ALUsign_o(ALUsign),
      .byteOp_o(byteOp), .NPCop_o(NPCop), .ALUop_o(ALUop), .ExtOp_o(ExtOp),
      .M2Rsel_o(M2Rsel), .GPRsel_o(GPRsel), .state_o(state), .trap_o(trap),
      .trap_code_o(trap_code), .ovf_flag_o(ovf_flag), .retired_o(retired));

   always #5 clk = ~clk;

   typedef struct packed {
      logic imem_req, dmem_req, PCWr, IRWr, GPRWr, DMWr, ALUsrc, ALUsign, byteOp;
      logic [1:0] NPCop, ALUop, ExtOp, M2Rsel, GPRsel;
      logic [2:0] state;
      logic trap;
      logic [1:0] trap_code;
      logic ovf_flag;
      logic [TB_CNT-1:0] retired;
   } out_t;

   out_t dut_o;
   assign dut_o = {imem_req, dmem_req, PCWr, IRWr, GPRWr, DMWr, ALUsrc, ALUsign, byteOp,
                   NPCop, ALUop, ExtOp, M2Rsel, GPRsel, state, trap, trap_code, ovf_flag,
                   retired};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int klass(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) begin
         case (f)
            6'h21: return K_ADDU;
            6'h23: return K_SUBU;
            6'h2a: return K_SLT;
            6'h08: return K_JR;
            default: return K_BAD;
         endcase
      end
      case (o)
         6'h08: return K_ADDI;  6'h0d: return K_ORI;  6'h0f: return K_LUI;
         6'h23: return K_LW;    6'h20: return K_LB;   6'h2b: return K_SW;
         6'h28: return K_SB;    6'h04: return K_BEQ;  6'h02: return K_J;
         6'h03: return K_JAL;
         default: return K_BAD;
      endcase
   endfunction

   // Phases an instruction visits after FETCH; finishing the list retires it.
   function automatic int route_next(input int k, input int ph);
      int r[$];
      case (k)
         K_JR, K_J, K_JAL: r = '{1};
         K_BEQ:            r = '{1, 2};
         K_LW, K_LB:       r = '{1, 2, 3, 4};
         K_SW, K_SB:       r = '{1, 2, 3};
         K_BAD:            r = '{1, 7};
         default:          r = '{1, 2, 4};
      endcase
      if (ph == 0) return r[0];
      for (int i = 0; i < r.size(); i++)
         if (r[i] == ph) return (i + 1 < r.size()) ? r[i+1] : 0;
      return 7;
   endfunction

   int m_ph = 0, m_wait = 0, n_ph = 0, n_wait = 0;
   logic [1:0] m_code = '0, n_code = '0;
   logic m_ovf = 1'b0, n_ovf = 1'b0;
   logic [TB_CNT-1:0] m_ret = '0, n_ret = '0;

   always @(negedge clk) begin : mdl
      out_t e;
      int k;
      logic ld, st, rt, rdy;
      k  = klass(op, funct);
      ld = (k == K_LW || k == K_LB);
      st = (k == K_SW || k == K_SB);
      rt = (k == K_ADDU || k == K_SUBU || k == K_SLT || k == K_JR);
      e = '0;
      e.state = 3'(m_ph); e.trap = (m_ph == 7); e.trap_code = m_code;
      e.ovf_flag = m_ovf; e.retired = m_ret;
      if (rst_n) begin
         if (m_ph == 2 || m_ph == 3 || m_ph == 4) begin
            e.ALUsrc  = (k == K_ADDI || k == K_ORI || k == K_LUI || ld || st);
            e.ExtOp   = (k == K_LUI) ? 2'd2 : (k == K_ADDI || ld || st) ? 2'd1 : 2'd0;
            e.ALUop   = (k == K_SUBU || k == K_BEQ) ? 2'd1 :
                        (k == K_ORI || k == K_LUI) ? 2'd2 : (k == K_SLT) ? 2'd3 : 2'd0;
            e.ALUsign = (k == K_ADDI || k == K_SLT);
         end
         case (m_ph)
            0: begin e.imem_req = 1'b1; e.IRWr = irdy; e.PCWr = irdy; end
            1: begin
               if (k == K_J || k == K_JAL) begin e.PCWr = 1'b1; e.NPCop = 2'd2; end
               if (k == K_JAL) begin e.GPRWr = 1'b1; e.GPRsel = 2'd2; e.M2Rsel = 2'd2; end
               if (k == K_JR)  begin e.PCWr = 1'b1; e.NPCop = 2'd3; end
            end
            2: if (k == K_BEQ) begin e.PCWr = zero; e.NPCop = 2'd1; end
            3: begin
               e.dmem_req = 1'b1;
               e.byteOp   = (k == K_LB || k == K_SB);
               e.DMWr     = st && drdy;
            end
            4: begin
               e.GPRWr  = !(k == K_ADDI && ovf);
               e.GPRsel = rt ? 2'd0 : 2'd1;
               e.M2Rsel = ld ? 2'd1 : 2'd0;
            end
            default: ;
         endcase
      end
      checks++;
      if (dut_o !== e) begin
         errors++;
         $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, dut_o, e);
      end
      n_ph = m_ph; n_wait = m_wait; n_code = m_code; n_ovf = m_ovf;
      if (m_ph != 7) begin
         if (m_ph == 0 || m_ph == 3) begin
            rdy = (m_ph == 0) ? irdy : drdy;
            if (rdy) n_ph = route_next(k, m_ph);
            else if (m_wait + 1 == TB_WAIT) begin
               n_ph = 7; n_code = (m_ph == 0) ? 2'd2 : 2'd3;
            end else n_wait = m_wait + 1;
         end else n_ph = route_next(k, m_ph);
      end
      if (n_ph != m_ph) n_wait = 0;
      if (m_ph == 4 && k == K_ADDI && ovf) n_ovf = 1'b1;
      n_ret = m_ret + ((n_ph == 0 && m_ph != 0) ? TB_CNT'(1) : TB_CNT'(0));
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0; m_wait <= 0; m_code <= '0; m_ovf <= 1'b0; m_ret <= '0;
      end else begin
         m_ph <= n_ph; m_wait <= n_wait; m_code <= n_code; m_ovf <= n_ovf; m_ret <= n_ret;
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct {
      string nm; logic [5:0] op, fn; logic z, v;
      int cyc, npc, ngpr, ndm;
   } vec_t;
   vec_t tbl[16];
   logic [TB_CNT-1:0] exp_ret = '0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_state", 32'(state), 0);
      chk("rst_imem_req", 32'(imem_req), 0);
      chk("rst_trap", 32'(trap), 0);
      chk("rst_code", 32'(trap_code), 0);
      chk("rst_ovf", 32'(ovf_flag), 0);
      chk("rst_retired", 32'(retired), 0);
      tick();
      rst_n = 1'b1;
      exp_ret = '0;
   endtask

   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input logic v, output int cyc, output int npc,
                            output int ngpr, output int ndm);
      op = o; funct = f; zero = z; ovf = v; irdy = 1'b1; drdy = 1'b1;
      cyc = 0; npc = 0; ngpr = 0; ndm = 0;
      do begin
         @(negedge clk);
         cyc++; npc += int'(PCWr); ngpr += int'(GPRWr); ndm += int'(DMWr);
         tick();
      end while (state != 3'd0 && cyc < 20);
   endtask

   task automatic run_until(input logic [2:0] st, input string nm);
      int c;
      c = 0;
      while (state != st && c < 20) begin
         @(negedge clk); tick(); c++;
      end
      if (state != st) chk({nm, "_timeout"}, 32'(state), 32'(st));
   endtask

   initial begin : main
      int cyc, npc, ngpr, ndm, n, mcnt, dm_at;
      tbl[0]  = '{"addu",   6'h00, 6'h21, 1'b0, 1'b0, 4, 1, 1, 0};
      tbl[1]  = '{"subu",   6'h00, 6'h23, 1'b0, 1'b0, 4, 1, 1, 0};
      tbl[2]  = '{"slt",    6'h00, 6'h2a, 1'b0, 1'b0, 4, 1, 1, 0};
      tbl[3]  = '{"jr",     6'h00, 6'h08, 1'b0, 1'b0, 2, 2, 0, 0};
      tbl[4]  = '{"addi",   6'h08, 6'h15, 1'b0, 1'b0, 4, 1, 1, 0};
      tbl[5]  = '{"addiov", 6'h08, 6'h15, 1'b0, 1'b1, 4, 1, 0, 0};
      tbl[6]  = '{"ori",    6'h0d, 6'h15, 1'b0, 1'b0, 4, 1, 1, 0};
      tbl[7]  = '{"lui",    6'h0f, 6'h15, 1'b0, 1'b0, 4, 1, 1, 0};
      tbl[8]  = '{"lw",     6'h23, 6'h15, 1'b0, 1'b0, 5, 1, 1, 0};
      tbl[9]  = '{"lb",     6'h20, 6'h15, 1'b0, 1'b0, 5, 1, 1, 0};
      tbl[10] = '{"sw",     6'h2b, 6'h15, 1'b0, 1'b0, 4, 1, 0, 1};
      tbl[11] = '{"sb",     6'h28, 6'h15, 1'b0, 1'b0, 4, 1, 0, 1};
      tbl[12] = '{"beq_t",  6'h04, 6'h15, 1'b1, 1'b0, 3, 2, 0, 0};
      tbl[13] = '{"beq_nt", 6'h04, 6'h15, 1'b0, 1'b0, 3, 1, 0, 0};
      tbl[14] = '{"j",      6'h02, 6'h15, 1'b0, 1'b0, 2, 2, 0, 0};
      tbl[15] = '{"jal",    6'h03, 6'h15, 1'b0, 1'b0, 2, 2, 1, 0};

      #2;
      do_reset();

      // Table: latency, strobe counts, retire count, sticky overflow
      foreach (tbl[i]) begin
         run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].v, cyc, npc, ngpr, ndm);
         exp_ret = exp_ret + TB_CNT'(1);
         chk({tbl[i].nm, "_cyc"},  32'(cyc),  32'(tbl[i].cyc));
         chk({tbl[i].nm, "_pcwr"}, 32'(npc),  32'(tbl[i].npc));
         chk({tbl[i].nm, "_gprwr"}, 32'(ngpr), 32'(tbl[i].ngpr));
         chk({tbl[i].nm, "_dmwr"}, 32'(ndm),  32'(tbl[i].ndm));
         chk({tbl[i].nm, "_ret"},  32'(retired), 32'(exp_ret));
         chk({tbl[i].nm, "_ovf"},  32'(ovf_flag), (i >= 5) ? 32'd1 : 32'd0);
      end

      // Illegal op and illegal funct
      do_reset();
      op = 6'h3f; funct = 6'h00; irdy = 1'b1;
      run_until(3'd7, "badop");
      chk("badop_code", 32'(trap_code), 1);
      do_reset();
      op = 6'h00; funct = 6'h3f;
      run_until(3'd7, "badfn");
      chk("badfn_code", 32'(trap_code), 1);
      do_reset();

      // imem ready on the last allowed cycle still succeeds
      op = 6'h00; funct = 6'h21; irdy = 1'b0;
      repeat (TB_WAIT - 1) begin @(negedge clk); tick(); end
      irdy = 1'b1;
      @(negedge clk);
      chk("imem_late_irwr", 32'(IRWr), 1);
      tick();
      chk("imem_late_state", 32'(state), 1);
      run_until(3'd0, "imem_late_done");

      // imem timeout
      irdy = 1'b0; n = 0;
      for (int c = 0; c < 20 && state != 3'd7; c++) begin
         @(negedge clk); if (state == 3'd0) n++; tick();
      end
      chk("imem_to_cycles", 32'(n), TB_WAIT);
      chk("imem_to_code", 32'(trap_code), 2);
      irdy = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("trap_hold", 32'(trap), 1);
         chk("trap_noreq", 32'(imem_req), 0);
         tick();
      end
      do_reset();

      // sw with dmem ready after 3 wait cycles
      op = 6'h2b; funct = 6'h00; irdy = 1'b1; drdy = 1'b0; mcnt = 0; dm_at = 0; ndm = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (state == 3'd3) begin
            mcnt++;
            if (DMWr) begin ndm++; dm_at = mcnt; end
         end
         tick();
         drdy = (mcnt >= 3);
         if (state == 3'd0 && mcnt > 0) break;
      end
      exp_ret = exp_ret + TB_CNT'(1);
      chk("sw_mem_cycles", 32'(mcnt), 4);
      chk("sw_dmwr_count", 32'(ndm), 1);
      chk("sw_dmwr_at", 32'(dm_at), 4);
      chk("sw_ret", 32'(retired), 32'(exp_ret));

      // lw with dmem never ready
      op = 6'h23; drdy = 1'b0; n = 0;
      for (int c = 0; c < 20 && state != 3'd7; c++) begin
         @(negedge clk); if (state == 3'd3) n++; tick();
      end
      chk("dmem_to_cycles", 32'(n), TB_WAIT);
      chk("dmem_to_code", 32'(trap_code), 3);
      do_reset();

      // Reset in the middle of a store access
      op = 6'h2b; drdy = 1'b0;
      run_until(3'd3, "abort_mem");
      @(negedge clk); tick();
      rst_n = 1'b0; drdy = 1'b1;
      @(negedge clk);
      chk("abort_dmwr", 32'(DMWr), 0);
      chk("abort_dreq", 32'(dmem_req), 0);
      chk("abort_state", 32'(state), 0);
      tick();
      rst_n = 1'b1; exp_ret = '0;
      @(negedge clk);
      chk("abort_fetch", 32'(state), 0);
      chk("abort_ireq", 32'(imem_req), 1);
      chk("abort_dmwr2", 32'(DMWr), 0);
      tick();

      // Retired counter wraps at 2^CNT_W
      do_reset();
      repeat (17) run_instr(6'h02, 6'h00, 1'b0, 1'b0, cyc, npc, ngpr, ndm);
      chk("ret_wrap", 32'(retired), 1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (state == 3'd7) do_reset();
         else begin
            if (state == 3'd0) begin
               n = $urandom_range(0, 16);
               if (n == 16) begin
                  op = 6'($urandom_range(0, 63)); funct = 6'($urandom_range(0, 63));
               end else begin
                  op = tbl[n].op; funct = tbl[n].fn;
               end
            end
            irdy = ($urandom_range(0, 5) != 0);
            drdy = ($urandom_range(0, 5) != 0);
            zero = 1'($urandom_range(0, 1));
            ovf  = 1'($urandom_range(0, 1));
            @(negedge clk); tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
